pipe_fwd_ctl: RTL

PIPE_FWD_CTL -- requirements
Module: pipe_fwd_ctl

---
 rtl/pipe_fwd_ctl_pkg.sv | 61 ++++++
 rtl/pipe_ctl_regs.sv | 50 +++++
 rtl/pipe_fwd_ctl.sv | 88 ++++++++
 3 files changed

// File: rtl/pipe_fwd_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fwd_ctl_pkg
//  Purpose  : Shared CPU encodings (forward selects, aluc, pcsource) and the
//             per-stage control record used by the pipeline control slice.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_fwd_ctl_pkg;

  localparam int REG_W = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF   = 2'b00;
  localparam fwd_sel_t FWD_EXE  = 2'b01;
  localparam fwd_sel_t FWD_MALU = 2'b10;
  localparam fwd_sel_t FWD_MMEM = 2'b11;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] PCSOURCE_SEQ  = 2'b00;
  localparam logic [1:0] PCSOURCE_BR   = 2'b01;
  localparam logic [1:0] PCSOURCE_JR   = 2'b10;
  localparam logic [1:0] PCSOURCE_JUMP = 2'b11;

  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic             wmem;
    logic [REG_W-1:0] rn;
  } stage_ctl_t;

  // EX wins over MEM because it holds the younger write of the same register;
  // an EX load is never forwarded, the load-use stall covers it instead.
  function automatic fwd_sel_t fwd_select(
    input logic             use_r,
    input logic [REG_W-1:0] r,
    input stage_ctl_t       e,
    input stage_ctl_t       m
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_r && e.wreg && !e.m2reg && (e.rn != '0) && (e.rn == r))
      sel = FWD_EXE;
    else if (use_r && m.wreg && !m.m2reg && (m.rn == r) && (m.rn != '0))
      sel = FWD_MALU;
    else if (use_r && m.wreg && m.m2reg && (m.rn == r) && (m.rn != '0))
      sel = FWD_MMEM;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctl_regs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctl_regs
//  Purpose  : ID->EX->MEM->WB control register chain with bubble insertion.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctl_regs
  import pipe_fwd_ctl_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  stage_ctl_t       id_ctl,
  output stage_ctl_t       e_ctl,
  output stage_ctl_t       m_ctl,
  output logic             w_wreg,
  output logic             w_m2reg,
  output logic [REG_W-1:0] w_rn
);

  stage_ctl_t       r_e;
  stage_ctl_t       r_m;
  logic             r_w_wreg;
  logic             r_w_m2reg;
  logic [REG_W-1:0] r_w_rn;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_e       <= '0;
      r_m       <= '0;
      r_w_wreg  <= 1'b0;
      r_w_m2reg <= 1'b0;
      r_w_rn    <= '0;
    end else begin
      r_e       <= load ? id_ctl : '0;
      r_m       <= r_e;
      r_w_wreg  <= r_m.wreg;
      r_w_m2reg <= r_m.m2reg;
      r_w_rn    <= r_m.rn;
    end
  end

  assign e_ctl   = r_e;
  assign m_ctl   = r_m;
  assign w_wreg  = r_w_wreg;
  assign w_m2reg = r_w_m2reg;
  assign w_rn    = r_w_rn;

endmodule
`default_nettype wire

// File: rtl/pipe_fwd_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fwd_ctl
//  Purpose  : Load-use stall, operand forwarding selects and stall counter
//             for a five-stage pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_fwd_ctl
  import pipe_fwd_ctl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             wreg,
  input  logic             m2reg,
  input  logic             wmem,
  input  logic [REG_W-1:0] rn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             e_wreg,
  output logic             e_m2reg,
  output logic             e_wmem,
  output logic [REG_W-1:0] e_rn,
  output logic             m_wreg,
  output logic             m_m2reg,
  output logic             m_wmem,
  output logic [REG_W-1:0] m_rn,
  output logic             w_wreg,
  output logic             w_m2reg,
  output logic [REG_W-1:0] w_rn,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_ctl_t       w_id_ctl;
  stage_ctl_t       w_e_ctl;
  stage_ctl_t       w_m_ctl;
  logic             w_load_use;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_id_ctl = '{wreg: wreg, m2reg: m2reg, wmem: wmem, rn: rn};

  pipe_ctl_regs u_regs (
    .clock   (clock),
    .resetn  (resetn),
    .load    (wpcir),
    .id_ctl  (w_id_ctl),
    .e_ctl   (w_e_ctl),
    .m_ctl   (w_m_ctl),
    .w_wreg  (w_wreg),
    .w_m2reg (w_m2reg),
    .w_rn    (w_rn)
  );

  // Load data is only available one stage later, so a consumer right behind
  // a load has to wait one cycle.
  assign w_load_use = w_e_ctl.m2reg & w_e_ctl.wreg & (w_e_ctl.rn != '0) &
                      ((use_rs & (rs == w_e_ctl.rn)) | (use_rt & (rt == w_e_ctl.rn)));
  assign wpcir      = ~w_load_use;

  assign fwda = fwd_select(use_rs, rs, w_e_ctl, w_m_ctl);
  assign fwdb = fwd_select(use_rt, rt, w_e_ctl, w_m_ctl);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_stall_cnt <= '0;
    else if (w_load_use)
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;

  assign e_wreg  = w_e_ctl.wreg;
  assign e_m2reg = w_e_ctl.m2reg;
  assign e_wmem  = w_e_ctl.wmem;
  assign e_rn    = w_e_ctl.rn;
  assign m_wreg  = w_m_ctl.wreg;
  assign m_m2reg = w_m_ctl.m2reg;
  assign m_wmem  = w_m_ctl.wmem;
  assign m_rn    = w_m_ctl.rn;

endmodule
`default_nettype wire
